hazard_gid: RTL and testbench
=============================

Name: hazard_gid

Overview:
- Per-stage instruction classifier for the MIPS hazard unit (addu, subu, ori, lui, lw, sw, beq, j, jal, jr).
- Decodes an instruction word plus the pipeline stage it occupies into the stall/forward quantities:
  - Tuse for rs and rt;
  - destination register A3;
  - a non-zero register-write flag;
  - Tnew relative to the current stage;
  - the data-port class of the write-back value.
- One instance per pipeline stage (D/E/M/W) feeds the stall comparator and forwarding muxes.
- Outputs are registered: one-cycle latency.

Parameters:
- TUSE_NONE, 3'd7, Tuse value for an operand the instruction does not read.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- IR  input  32  instruction word.
- Pipe  input  3  stage holding IR: 1=D, 2=E, 3=M, 4=W; any other value is invalid.
- Tuse_Rs  output  3  cycles (counted from D) until rs is consumed.
- Tuse_Rt  output  3  cycles (counted from D) until rt is consumed.
- RegWriteNonZero  output  1  instruction writes a GPR and A3 != 0.
- A3  output  5  destination register; 0 when there is no write.
- Tnew  output  3  cycles from the current stage until the result is available.
- DPort  output  3  result source: 0 none, 1 ALU, 2 data memory, 3 PC+8.

Behaviour:
- Timing:
  - On each rising clk edge, all outputs load the decode of IR and Pipe sampled at that edge.
  - No enable input; no handshake.
- Reset:
  - reset=1 at the edge loads the nop decode: Tuse_Rs=Tuse_Rt=7, RegWriteNonZero=0, A3=0, Tnew=0, DPort=0.
  - reset has priority over decode.
- Decode keys:
  - Opcode is IR[31:26]; funct is IR[5:0] when opcode=0.
  - rs=IR[25:21], rt=IR[20:16], rd=IR[15:11].
- Tuse (independent of Pipe):
  - addu/subu: 1/1.
  - ori, lw: rs 1, rt 7.
  - lui: 7/7.
  - sw: rs 1, rt 2.
  - beq: 0/0.
  - jr: rs 0, rt 7.
  - j, jal, unknown: 7/7.
- Base Tnew (value at D), destination and DPort:
  - addu/subu: base 2, A3=rd, DPort=1.
  - ori/lui: base 2, A3=rt, DPort=1.
  - lw: base 3, A3=rt, DPort=2.
  - jal: base 0, A3=31, DPort=3.
  - All other instructions: no write, A3=0, DPort=0, Tnew=0.
- Tnew output = max(base - (Pipe-1), 0), saturating at 0 (no wrap).
  - Example lw: D 3, E 2, M 1, W 0.
- RegWriteNonZero = write-class instruction AND A3 != 0.
  - A write to $0 still reports A3=0 and DPort per class; RegWriteNonZero=0.
- Invalid Pipe (0, 5–7):
  - RegWriteNonZero=0, A3=0, Tnew=0, DPort=0.
  - Tuse still decoded.
- Unknown opcode/funct decodes as nop; no X propagation.

Optional Feature:
- Macro: GID_EXT_ISA_EN.
- When defined, adds three R-type decodes:
  - sll (funct 0x00): rs 7, rt 1, base 2, A3=rd, DPort=1.
  - slt (funct 0x2A): 1/1, base 2, A3=rd, DPort=1.
  - jalr (funct 0x09): rs 0, rt 7, base 0, A3=rd, DPort=3.
- With sll enabled, IR=0 decodes as sll $0: Tuse_Rt=1, RegWriteNonZero=0.
- When undefined, these encodings decode as unknown (nop).

Decomposition:
- Shared package gid_pkg:
  - opcode/funct constants;
  - TUSE_NONE;
  - stage codes (STAGE_D..STAGE_W);
  - DPort codes (DP_NONE, DP_ALU, DP_DM, DP_PC8).
- One combinational sub-module, gid_class_decode:
  - maps IR to Tuse_Rs, Tuse_Rt, base Tnew, A3, write flag and DPort.
- The top applies Pipe adjustment and the output register.

Test Plan:
- Reset, IR=0, Pipe=1 (base ISA) -> Tuse 7/7, A3=0, RegWriteNonZero=0, Tnew=0, DPort=0.
- addu IR=0x01084821:
  - Pipe=1 -> Tuse 1/1, A3=9, RegWriteNonZero=1, Tnew=2, DPort=1.
  - Pipe=2 -> Tnew=1.
  - Pipe=4 -> Tnew=0.
  - All outputs one clock after the inputs change.
- lw IR=0x8d4b0000, Pipe=1..4 -> A3=11, DPort=2, Tuse 1/7, Tnew 3,2,1,0.
- sw IR=0xad6b0000 -> Tuse 1/2, RegWriteNonZero=0, A3=0.
- beq IR=0x116b0000 -> Tuse 0/0. jr IR=0x01600008 -> Tuse 0/7. j IR=0x08000c05 -> Tuse 7/7, no write.
- jal IR=0x0c000c05, Pipe=1 -> A3=31, DPort=3, Tnew=0.
  - Then Pipe=5 -> A3=0, RegWriteNonZero=0, Tuse 7/7.
  - Assert reset mid-stream -> nop values on the next edge.

Source files
------------

// File: rtl/gid_pkg.sv
// Shared constants and types for the hazard-unit instruction classifier (hazard_gid).
// Optional extended R-type decodes are controlled by the GID_EXT_ISA_EN macro.
package gid_pkg;

    localparam logic [2:0] TUSE_NONE = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [2:0] {
        STAGE_D = 3'd1,
        STAGE_E = 3'd2,
        STAGE_M = 3'd3,
        STAGE_W = 3'd4
    } stage_e;

    typedef enum logic [2:0] {
        DP_NONE = 3'd0,
        DP_ALU  = 3'd1,
        DP_DM   = 3'd2,
        DP_PC8  = 3'd3
    } dport_e;

    typedef struct packed {
        logic [2:0] tuse_rs;
        logic [2:0] tuse_rt;
        logic [2:0] tnew_base;
        logic [4:0] a3;
        logic       wr;
        dport_e     dport;
    } gid_dec_t;

endpackage

// File: rtl/gid_class_decode.sv
// Stage-independent instruction classification: Tuse, base Tnew (at D), destination,
// write flag and result port. Extended R-type decodes under GID_EXT_ISA_EN.
module gid_class_decode
    import gid_pkg::*;
(
    input  logic [31:0] IR,
    output gid_dec_t    dec
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_fields;

    assign opcode = IR[31:26];
    assign funct  = IR[5:0];
    assign rt     = IR[20:16];
    assign rd     = IR[15:11];
    assign unused_fields = ^{IR[25:21], IR[10:6]};

    always_comb begin
        dec = '{tuse_rs: TUSE_NONE, tuse_rt: TUSE_NONE, tnew_base: 3'd0,
                a3: 5'd0, wr: 1'b0, dport: DP_NONE};
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU: begin
                        dec = '{tuse_rs: 3'd1, tuse_rt: 3'd1, tnew_base: 3'd2,
                                a3: rd, wr: 1'b1, dport: DP_ALU};
                    end
                    FN_JR: begin
                        dec.tuse_rs = 3'd0;
                    end
`ifdef GID_EXT_ISA_EN
                    FN_SLL: begin
                        dec = '{tuse_rs: TUSE_NONE, tuse_rt: 3'd1, tnew_base: 3'd2,
                                a3: rd, wr: 1'b1, dport: DP_ALU};
                    end
                    FN_SLT: begin
                        dec = '{tuse_rs: 3'd1, tuse_rt: 3'd1, tnew_base: 3'd2,
                                a3: rd, wr: 1'b1, dport: DP_ALU};
                    end
                    FN_JALR: begin
                        dec = '{tuse_rs: 3'd0, tuse_rt: TUSE_NONE, tnew_base: 3'd0,
                                a3: rd, wr: 1'b1, dport: DP_PC8};
                    end
`endif
                    default: ;
                endcase
            end
            OP_ORI: begin
                dec = '{tuse_rs: 3'd1, tuse_rt: TUSE_NONE, tnew_base: 3'd2,
                        a3: rt, wr: 1'b1, dport: DP_ALU};
            end
            OP_LUI: begin
                dec = '{tuse_rs: TUSE_NONE, tuse_rt: TUSE_NONE, tnew_base: 3'd2,
                        a3: rt, wr: 1'b1, dport: DP_ALU};
            end
            OP_LW: begin
                dec = '{tuse_rs: 3'd1, tuse_rt: TUSE_NONE, tnew_base: 3'd3,
                        a3: rt, wr: 1'b1, dport: DP_DM};
            end
            OP_SW: begin
                dec.tuse_rs = 3'd1;
                dec.tuse_rt = 3'd2;
            end
            OP_BEQ: begin
                dec.tuse_rs = 3'd0;
                dec.tuse_rt = 3'd0;
            end
            OP_JAL: begin
                dec = '{tuse_rs: TUSE_NONE, tuse_rt: TUSE_NONE, tnew_base: 3'd0,
                        a3: REG_RA, wr: 1'b1, dport: DP_PC8};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_gid.sv
// Per-stage hazard classifier: decodes IR, ages Tnew by pipeline stage, registers outputs.
// Build option: GID_EXT_ISA_EN adds sll/slt/jalr decodes.
module hazard_gid
    import gid_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic [2:0]  Pipe,
    output logic [2:0]  Tuse_Rs,
    output logic [2:0]  Tuse_Rt,
    output logic        RegWriteNonZero,
    output logic [4:0]  A3,
    output logic [2:0]  Tnew,
    output logic [2:0]  DPort
);

    gid_dec_t   dec;
    logic       pipe_ok;
    logic [2:0] age;
    logic [2:0] tnew_aged;

    gid_class_decode u_class_decode (
        .IR  (IR),
        .dec (dec)
    );

    assign pipe_ok = (Pipe >= STAGE_D) && (Pipe <= STAGE_W);
    assign age     = Pipe - 3'd1;
    // Saturating subtract: a result already produced stays at 0 instead of wrapping.
    assign tnew_aged = (dec.tnew_base > age) ? (dec.tnew_base - age) : 3'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            Tuse_Rs         <= TUSE_NONE;
            Tuse_Rt         <= TUSE_NONE;
            RegWriteNonZero <= 1'b0;
            A3              <= '0;
            Tnew            <= '0;
            DPort           <= DP_NONE;
        end else begin
            Tuse_Rs <= dec.tuse_rs;
            Tuse_Rt <= dec.tuse_rt;
            if (pipe_ok) begin
                RegWriteNonZero <= dec.wr && (dec.a3 != 5'd0);
                A3              <= dec.a3;
                Tnew            <= tnew_aged;
                DPort           <= dec.dport;
            end else begin
                RegWriteNonZero <= 1'b0;
                A3              <= '0;
                Tnew            <= '0;
                DPort           <= DP_NONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_gid.sv
// Self-checking bench for hazard_gid: directed plan steps followed by randomized
// instructions, all compared against an instruction-level reference model.
module tb_hazard_gid;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR;
    logic [2:0]  Pipe;
    logic [2:0]  Tuse_Rs;
    logic [2:0]  Tuse_Rt;
    logic        RegWriteNonZero;
    logic [4:0]  A3;
    logic [2:0]  Tnew;
    logic [2:0]  DPort;

    int n_cmp = 0;
    int n_err = 0;

    hazard_gid dut (
        .clk             (clk),
        .reset           (reset),
        .IR              (IR),
        .Pipe            (Pipe),
        .Tuse_Rs         (Tuse_Rs),
        .Tuse_Rt         (Tuse_Rt),
        .RegWriteNonZero (RegWriteNonZero),
        .A3              (A3),
        .Tnew            (Tnew),
        .DPort           (DPort)
    );

    always #5 clk = ~clk;

    typedef struct {
        int trs;
        int trt;
        int wnz;
        int a3;
        int tnew;
        int dp;
    } exp_t;

    // Reference: classify by instruction name, then apply the stage rules arithmetically.
    function automatic exp_t model(input logic [31:0] ir, input int pipe, input bit rst);
        exp_t  e;
        string name;
        int    base = 0;
        int    dst  = 0;
        int    dp   = 0;
        bit    wr   = 0;
        int    rtf  = int'(ir[20:16]);
        int    rdf  = int'(ir[15:11]);
        e = '{trs: 7, trt: 7, wnz: 0, a3: 0, tnew: 0, dp: 0};
        if (rst) return e;
        name = "nop";
        case (ir[31:26])
            6'h00: begin
                case (ir[5:0])
                    6'h21: name = "addu";
                    6'h23: name = "subu";
                    6'h08: name = "jr";
`ifdef GID_EXT_ISA_EN
                    6'h00: name = "sll";
                    6'h2a: name = "slt";
                    6'h09: name = "jalr";
`endif
                    default: name = "nop";
                endcase
            end
            6'h0d: name = "ori";
            6'h0f: name = "lui";
            6'h23: name = "lw";
            6'h2b: name = "sw";
            6'h04: name = "beq";
            6'h02: name = "j";
            6'h03: name = "jal";
            default: name = "nop";
        endcase
        if (name == "addu" || name == "subu" || name == "slt") begin
            e.trs = 1; e.trt = 1; base = 2; dst = rdf; dp = 1; wr = 1;
        end else if (name == "sll") begin
            e.trt = 1; base = 2; dst = rdf; dp = 1; wr = 1;
        end else if (name == "ori") begin
            e.trs = 1; base = 2; dst = rtf; dp = 1; wr = 1;
        end else if (name == "lui") begin
            base = 2; dst = rtf; dp = 1; wr = 1;
        end else if (name == "lw") begin
            e.trs = 1; base = 3; dst = rtf; dp = 2; wr = 1;
        end else if (name == "sw") begin
            e.trs = 1; e.trt = 2;
        end else if (name == "beq") begin
            e.trs = 0; e.trt = 0;
        end else if (name == "jr") begin
            e.trs = 0;
        end else if (name == "jal") begin
            dst = 31; dp = 3; wr = 1;
        end else if (name == "jalr") begin
            e.trs = 0; dst = rdf; dp = 3; wr = 1;
        end
        if (pipe >= 1 && pipe <= 4) begin
            e.a3   = dst;
            e.dp   = dp;
            e.wnz  = (wr && dst != 0) ? 1 : 0;
            e.tnew = base - (pipe - 1);
            if (e.tnew < 0) e.tnew = 0;
        end
        return e;
    endfunction

    task automatic cmp(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] ir, input logic [2:0] pipe, input logic rst);
        IR    = ir;
        Pipe  = pipe;
        reset = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] ir, input int pipe,
                             input bit rst);
        exp_t e;
        e = model(ir, pipe, rst);
        cmp({tag, ".Tuse_Rs"}, int'(Tuse_Rs), e.trs);
        cmp({tag, ".Tuse_Rt"}, int'(Tuse_Rt), e.trt);
        cmp({tag, ".RegWriteNonZero"}, int'(RegWriteNonZero), e.wnz);
        cmp({tag, ".A3"}, int'(A3), e.a3);
        cmp({tag, ".Tnew"}, int'(Tnew), e.tnew);
        cmp({tag, ".DPort"}, int'(DPort), e.dp);
    endtask

    task automatic run(input string tag, input logic [31:0] ir, input logic [2:0] pipe,
                       input logic rst);
        step(ir, pipe, rst);
        check_all(tag, ir, int'(pipe), rst);
    endtask

    logic [31:0] rir;
    logic [2:0]  rpipe;
    logic        rrst;
    int          sel;

    initial begin
        IR    = '0;
        Pipe  = 3'd1;
        reset = 1'b1;
        @(negedge clk);

        run("reset", 32'h0000_0000, 3'd1, 1'b1);
        cmp("reset.A3_const", int'(A3), 0);
        cmp("reset.Tuse_Rs_const", int'(Tuse_Rs), 7);

        // Inputs change between edges; outputs must hold until the next edge.
        IR = 32'h0108_4821; Pipe = 3'd1; reset = 1'b0;
        #1;
        cmp("latency.A3_hold", int'(A3), 0);
        cmp("latency.RWNZ_hold", int'(RegWriteNonZero), 0);
        @(posedge clk); #1;
        check_all("addu.D", 32'h0108_4821, 1, 1'b0);
        cmp("addu.D.A3_const", int'(A3), 9);
        cmp("addu.D.Tnew_const", int'(Tnew), 2);
        run("addu.E", 32'h0108_4821, 3'd2, 1'b0);
        cmp("addu.E.Tnew_const", int'(Tnew), 1);
        run("addu.W", 32'h0108_4821, 3'd4, 1'b0);
        cmp("addu.W.Tnew_const", int'(Tnew), 0);

        for (int p = 1; p <= 4; p++) begin
            run($sformatf("lw.P%0d", p), 32'h8d4b_0000, 3'(p), 1'b0);
            cmp($sformatf("lw.P%0d.Tnew_const", p), int'(Tnew), 4 - p);
        end
        run("sw",  32'had6b_0000, 3'd1, 1'b0);
        run("beq", 32'h116b_0000, 3'd1, 1'b0);
        run("jr",  32'h0160_0008, 3'd1, 1'b0);
        run("j",   32'h0800_0c05, 3'd1, 1'b0);
        run("jal.D", 32'h0c00_0c05, 3'd1, 1'b0);
        cmp("jal.D.A3_const", int'(A3), 31);
        cmp("jal.D.DPort_const", int'(DPort), 3);
        run("jal.P5", 32'h0c00_0c05, 3'd5, 1'b0);
        run("jal.P0", 32'h0c00_0c05, 3'd0, 1'b0);
        run("addu_rd0", 32'h0108_0021, 3'd1, 1'b0);
        run("ori_rt0",  32'h3400_1234, 3'd2, 1'b0);
        run("lui.W",    32'h3c05_0001, 3'd4, 1'b0);
        run("lw.P7",    32'h8d4b_0000, 3'd7, 1'b0);
        run("ir_zero",  32'h0000_0000, 3'd1, 1'b0);
        run("slt",      32'h0109_502a, 3'd1, 1'b0);
        run("jalr",     32'h0140_f809, 3'd2, 1'b0);
        run("midreset", 32'h8d4b_0000, 3'd1, 1'b1);
        run("after_reset", 32'h8d4b_0000, 3'd2, 1'b0);

        for (int i = 0; i < 400; i++) begin
            rir = $urandom;
            if ($urandom_range(0, 3) == 0) rir[20:11] = '0;
            sel = $urandom_range(0, 13);
            case (sel)
                0:  begin rir[31:26] = 6'h00; rir[5:0] = 6'h21; end
                1:  begin rir[31:26] = 6'h00; rir[5:0] = 6'h23; end
                2:  rir[31:26] = 6'h0d;
                3:  rir[31:26] = 6'h0f;
                4:  rir[31:26] = 6'h23;
                5:  rir[31:26] = 6'h2b;
                6:  rir[31:26] = 6'h04;
                7:  rir[31:26] = 6'h02;
                8:  rir[31:26] = 6'h03;
                9:  begin rir[31:26] = 6'h00; rir[5:0] = 6'h08; end
                10: begin rir[31:26] = 6'h00; rir[5:0] = 6'h00; end
                11: begin rir[31:26] = 6'h00; rir[5:0] = 6'h2a; end
                12: begin rir[31:26] = 6'h00; rir[5:0] = 6'h09; end
                default: ;
            endcase
            rpipe = 3'($urandom_range(0, 7));
            rrst  = ($urandom_range(0, 19) == 0);
            run($sformatf("rand%0d", i), rir, rpipe, rrst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
